// File: rtl/dsc_pkg.sv
// ---------------------------------------------------------------------------
// dsc_pkg
// Shared definitions for the dual-slope conversion counter:
//   - default run-up length / full-scale and counter width
//   - FSM state encoding
//   - control bundle driven from the FSM into the counting sub-module
// ---------------------------------------------------------------------------
package dsc_pkg;

  localparam int unsigned DSC_FULL_COUNT = 32'd1000;
  localparam int unsigned DSC_CNT_W      = 32'd10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN_UP   = 2'b01,
    ST_RUN_DOWN = 2'b10,
    ST_DONE     = 2'b11
  } dsc_state_e;

  // One cycle's worth of counter commands; priority clear > load_one > inc.
  // sat selects what inc does at terminal count: hold (1) or wrap to 0 (0).
  typedef struct packed {
    logic clear;
    logic load_one;
    logic inc;
    logic sat;
  } dsc_cnt_ctrl_t;

endpackage

// File: rtl/dsc_mod_counter.sv
// ---------------------------------------------------------------------------
// dsc_mod_counter
// Up-counter used for both integration slopes.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset (count -> 0)
//   i_ctrl   in  clear / load-one / increment / saturate command bundle
//   o_count  out registered count value
//   o_tc     out terminal-count flag (count == FULL_COUNT-1)
// ---------------------------------------------------------------------------
module dsc_mod_counter
  import dsc_pkg::*;
#(
  parameter int unsigned FULL_COUNT = DSC_FULL_COUNT,
  parameter int unsigned CNT_W      = DSC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  dsc_cnt_ctrl_t    i_ctrl,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(FULL_COUNT - 32'd1);

  logic [CNT_W-1:0] r_count;
  logic             w_tc;

  assign w_tc    = (r_count == TC_VAL);
  assign o_count = r_count;
  assign o_tc    = w_tc;

  // Count register: reset/clear to zero, load one on a new start, step otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_ctrl.clear) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_ctrl.load_one) begin
      r_count <= CNT_W'(1'b1);
    end else if (i_ctrl.inc) begin
      if (w_tc) begin
        // Run-down holds at full scale; run-up wraps to start run-down at 0.
        r_count <= i_ctrl.sat ? r_count : {CNT_W{1'b0}};
      end else begin
        r_count <= r_count + CNT_W'(1'b1);
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/dual_slope_counter.sv
// ---------------------------------------------------------------------------
// dual_slope_counter
// Sequencer for a dual-slope ADC: times a fixed run-up of FULL_COUNT enabled
// cycles, pulses enb_machine when run-up ends, then counts run-down until the
// controller strobes ld, which latches the run-down count as the result.
// Ports:
//   clk          in  clock, rising edge
//   rst          in  synchronous active-high reset
//   clr          in  per-conversion clear (keeps result/result_valid)
//   enb_cnt      in  count enable
//   ld           in  capture strobe (honoured only during run-down)
//   result_ack   in  consumer acknowledge, clears result_valid
//   enb_machine  out one-cycle pulse at end of run-up
//   count        out live counter value
//   result       out latched run-down count
//   result_valid out result held and not yet acknowledged
//   overrange    out run-down hit full scale
// ---------------------------------------------------------------------------
module dual_slope_counter
  import dsc_pkg::*;
#(
  parameter int unsigned FULL_COUNT = DSC_FULL_COUNT,
  parameter int unsigned CNT_W      = DSC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             enb_cnt,
  input  logic             ld,
  input  logic             result_ack,
  output logic             enb_machine,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             overrange
);

  dsc_state_e       r_state;
  logic             r_enb_machine;
  logic [CNT_W-1:0] r_result;
  logic             r_result_valid;
  logic             r_overrange;

  dsc_cnt_ctrl_t    w_ctrl;
  logic [CNT_W-1:0] w_count;
  logic             w_tc;
  logic             w_capture;

  // ld is honoured only in run-down and loses to clr.
  assign w_capture = ~clr & ld & (r_state == ST_RUN_DOWN);

  // Translate FSM state and controller inputs into counter commands
  always_comb begin
    w_ctrl = '{clear: 1'b0, load_one: 1'b0, inc: 1'b0, sat: 1'b0};
    if (clr) begin
      w_ctrl.clear = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          w_ctrl.load_one = enb_cnt;
        end
        ST_RUN_UP: begin
          w_ctrl.inc = enb_cnt;
        end
        ST_RUN_DOWN: begin
          // A capture freezes the count so it matches the latched result.
          w_ctrl.inc = enb_cnt & ~ld;
          w_ctrl.sat = 1'b1;
        end
        default: begin
          w_ctrl.clear = 1'b1;
        end
      endcase
    end
  end

  dsc_mod_counter #(
    .FULL_COUNT (FULL_COUNT),
    .CNT_W      (CNT_W)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .i_ctrl  (w_ctrl),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  // Conversion FSM with registered pulse, flag and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_enb_machine  <= 1'b0;
      r_result       <= {CNT_W{1'b0}};
      r_result_valid <= 1'b0;
      r_overrange    <= 1'b0;
    end else begin
      r_enb_machine <= 1'b0;

      if (clr) begin
        r_state     <= ST_IDLE;
        r_overrange <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (enb_cnt) begin
              r_state <= ST_RUN_UP;
            end
          end
          ST_RUN_UP: begin
            if (enb_cnt && w_tc) begin
              r_state       <= ST_RUN_DOWN;
              r_enb_machine <= 1'b1;
            end
          end
          ST_RUN_DOWN: begin
            if (ld) begin
              r_state  <= ST_DONE;
              r_result <= w_count;
            end else if (enb_cnt && w_tc) begin
              r_overrange <= 1'b1;
            end
          end
          ST_DONE: begin
            if (enb_cnt) begin
              r_state     <= ST_RUN_UP;
              r_overrange <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end

      // A fresh capture wins over an acknowledge in the same cycle.
      if (w_capture) begin
        r_result_valid <= 1'b1;
      end else if (result_ack) begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign enb_machine  = r_enb_machine;
  assign count        = w_count;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign overrange    = r_overrange;

endmodule

// File: tb/tb_dual_slope_counter.sv
// ---------------------------------------------------------------------------
// tb_dual_slope_counter
// Self-checking bench for dual_slope_counter with FULL_COUNT=16, CNT_W=5.
// A behavioural model tracks the conversion phase and counts with plain
// integer arithmetic; directed scenarios also check fixed expected values.
// ---------------------------------------------------------------------------
module tb_dual_slope_counter;

  localparam int FC = 16;
  localparam int CW = 5;

  localparam int P_IDLE = 0;
  localparam int P_UP   = 1;
  localparam int P_DOWN = 2;
  localparam int P_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          enb_cnt = 1'b0;
  logic          ld = 1'b0;
  logic          result_ack = 1'b0;
  logic          enb_machine;
  logic [CW-1:0] count;
  logic [CW-1:0] result;
  logic          result_valid;
  logic          overrange;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_phase  = P_IDLE;
  int m_count  = 0;
  int m_result = 0;
  bit m_rv     = 1'b0;
  bit m_em     = 1'b0;
  bit m_ovr    = 1'b0;

  dual_slope_counter #(
    .FULL_COUNT (FC),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .enb_cnt      (enb_cnt),
    .ld           (ld),
    .result_ack   (result_ack),
    .enb_machine  (enb_machine),
    .count        (count),
    .result       (result),
    .result_valid (result_valid),
    .overrange    (overrange)
  );

  always #5 clk = ~clk;

  // Advance the reference model by one clock edge given the inputs seen there.
  task automatic model_step(input bit r, input bit c, input bit e, input bit l, input bit a);
    bit cap;
    if (r) begin
      m_phase = P_IDLE; m_count = 0; m_result = 0;
      m_rv = 0; m_em = 0; m_ovr = 0;
    end else begin
      cap  = !c && l && (m_phase == P_DOWN);
      m_em = 0;
      if (c) begin
        m_phase = P_IDLE; m_count = 0; m_ovr = 0;
      end else if (m_phase == P_IDLE || m_phase == P_DONE) begin
        if (e) begin
          m_phase = P_UP; m_count = 1; m_ovr = 0;
        end
      end else if (m_phase == P_UP) begin
        if (e) begin
          if (m_count == FC - 1) begin
            m_count = 0; m_phase = P_DOWN; m_em = 1;
          end else begin
            m_count = m_count + 1;
          end
        end
      end else begin
        if (l) begin
          m_result = m_count; m_phase = P_DONE;
        end else if (e) begin
          if (m_count == FC - 1) m_ovr = 1;
          else m_count = m_count + 1;
        end
      end
      if (cap) m_rv = 1;
      else if (a) m_rv = 0;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, update the model, settle.
  task automatic tick(input bit r, input bit c, input bit e, input bit l, input bit a);
    rst = r; clr = c; enb_cnt = e; ld = l; result_ack = a;
    @(posedge clk);
    model_step(r, c, e, l, a);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 1, 1, 0);
    checks++;
    if (count !== 5'd0 || result !== 5'd0 || result_valid !== 1'b0 ||
        enb_machine !== 1'b0 || overrange !== 1'b0) begin
      failures++;
      $display("FAIL reset count=%0d result=%0d rv=%0b em=%0b ovr=%0b, want all 0",
               count, result, result_valid, enb_machine, overrange);
    end
  endtask

  task automatic test_run_up();
    int em_hits;
    logic [CW-1:0] exp_c;
    em_hits = 0;
    tick(1, 0, 0, 0, 0);
    for (int i = 1; i <= FC; i++) begin
      tick(0, 0, 1, 0, 0);
      exp_c = CW'(i % FC);
      if (enb_machine === 1'b1) em_hits++;
      checks++;
      if (count !== exp_c || enb_machine !== (i == FC)) begin
        failures++;
        $display("FAIL run_up step=%0d count=%0d want %0d em=%0b want %0b",
                 i, count, exp_c, enb_machine, (i == FC));
      end
    end
    checks++;
    if (em_hits != 1) begin
      failures++;
      $display("FAIL run_up_pulse_count got %0d want 1", em_hits);
    end
  endtask

  task automatic test_capture();
    for (int i = 1; i <= 9; i++) begin
      tick(0, 0, 1, 0, 0);
      checks++;
      if (count !== CW'(i) || enb_machine !== 1'b0) begin
        failures++;
        $display("FAIL run_down step=%0d count=%0d want %0d em=%0b want 0", i, count, i, enb_machine);
      end
    end
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 1, 1, 0);  // DONE: ld ignored, enb restarts
    tick(0, 0, 0, 0, 0);
    checks++;
    if (result !== 5'd9 || result_valid !== 1'b1 || count !== 5'd1) begin
      failures++;
      $display("FAIL capture result=%0d want 9 rv=%0b want 1 count=%0d want 1",
               result, result_valid, count);
    end
  endtask

  task automatic test_overrange();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < FC + 20; i++) tick(0, 0, 1, 0, 0);
    checks++;
    if (count !== 5'd15 || overrange !== 1'b1) begin
      failures++;
      $display("FAIL overrange count=%0d want 15 ovr=%0b want 1", count, overrange);
    end
    tick(0, 0, 1, 1, 0);
    checks++;
    if (result !== 5'd15 || result_valid !== 1'b1 || count !== 5'd15) begin
      failures++;
      $display("FAIL overrange_capture result=%0d want 15 rv=%0b count=%0d", result, result_valid, count);
    end
  endtask

  task automatic test_ack_collision();
    tick(0, 0, 1, 0, 0);
    checks++;
    if (overrange !== 1'b0 || count !== 5'd1) begin
      failures++;
      $display("FAIL restart ovr=%0b want 0 count=%0d want 1", overrange, count);
    end
    for (int i = 0; i < FC - 1 + 5; i++) tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 1);
    checks++;
    if (result_valid !== 1'b1 || result !== 5'd5) begin
      failures++;
      $display("FAIL ack_collision rv=%0b want 1 result=%0d want 5", result_valid, result);
    end
    tick(0, 0, 0, 0, 1);
    checks++;
    if (result_valid !== 1'b0 || result !== 5'd5) begin
      failures++;
      $display("FAIL ack_clear rv=%0b want 0 result=%0d want 5", result_valid, result);
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < FC + 3; i++) tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0);  // result 3 held
    for (int i = 0; i < 7; i++) tick(0, 0, 1, 0, 0);
    checks++;
    if (count !== 5'd7) begin
      failures++;
      $display("FAIL clr_setup count=%0d want 7", count);
    end
    tick(0, 1, 1, 1, 0);
    checks++;
    if (count !== 5'd0 || enb_machine !== 1'b0 || result !== 5'd3 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL clr count=%0d want 0 em=%0b result=%0d want 3 rv=%0b want 1",
               count, enb_machine, result, result_valid);
    end
    for (int i = 1; i <= 8; i++) begin
      tick(0, 0, 1, 0, 0);
      checks++;
      if (enb_machine !== 1'b0 || count !== CW'(i)) begin
        failures++;
        $display("FAIL post_clr step=%0d em=%0b want 0 count=%0d want %0d", i, enb_machine, count, i);
      end
    end
  endtask

  task automatic test_rst_mid();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < FC + 4; i++) tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0);  // capture 4 so that the reset visibly wipes it
    tick(0, 0, 1, 0, 0);
    for (int i = 0; i < FC + 3; i++) tick(0, 0, 1, 0, 0);
    checks++;
    if (count !== 5'd4 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_setup count=%0d want 4 rv=%0b want 1", count, result_valid);
    end
    tick(1, 0, 1, 1, 0);
    checks++;
    if (result !== 5'd0 || result_valid !== 1'b0 || count !== 5'd0 || enb_machine !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid result=%0d rv=%0b count=%0d em=%0b want all 0",
               result, result_valid, count, enb_machine);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1, 0);
      checks++;
      if (result_valid !== 1'b0 || result !== 5'd0 || enb_machine !== 1'b0 || count !== 5'd0) begin
        failures++;
        $display("FAIL rst_idle_ld rv=%0b result=%0d em=%0b count=%0d want all 0",
                 result_valid, result, enb_machine, count);
      end
    end
  endtask

  task automatic test_random();
    bit r, c, e, l, a;
    int ld_range;
    tick(1, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      ld_range = ((n / 500) % 2 == 0) ? 4 : 40;
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, ld_range - 1) == 0);
      a = ($urandom_range(0, 3) == 0);
      tick(r, c, e, l, a);
      checks++;
      if (count !== m_count[CW-1:0] || result !== m_result[CW-1:0] || result_valid !== m_rv ||
          enb_machine !== m_em || overrange !== m_ovr) begin
        failures++;
        $display("FAIL random cyc=%0d count=%0d/%0d result=%0d/%0d rv=%0b/%0b em=%0b/%0b ovr=%0b/%0b (got/want)",
                 n, count, m_count, result, m_result, result_valid, m_rv,
                 enb_machine, m_em, overrange, m_ovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_up();
    test_capture();
    test_overrange();
    test_ack_collision();
    test_clr();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_slope_counter.md
DUAL_SLOPE_COUNTER -- requirements
Module: dual_slope_counter

Interface
REQ-001 SHALL have parameter FULL_COUNT, default 1000: run-up length in clk cycles and run-down full-scale.
REQ-002 SHALL have parameter CNT_W, default 10: counter/result width; CNT_W SHALL be large enough to hold FULL_COUNT-1.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-005 SHALL have port clr  in  1  per-conversion clear from the controller; synchronous, active-high.
REQ-006 SHALL have port enb_cnt  in  1  count enable from the controller.
REQ-007 SHALL have port ld  in  1  load strobe; captures the run-down count.
REQ-008 SHALL have port result_ack  in  1  consumer acknowledge of result.
REQ-009 SHALL have port enb_machine  out  1  one-cycle pulse marking the end of run-up.
REQ-010 SHALL have port count  out  CNT_W  live counter value.
REQ-011 SHALL have port result  out  CNT_W  latched conversion result.
REQ-012 SHALL have port result_valid  out  1  result held and unacknowledged.
REQ-013 SHALL have port overrange  out  1  run-down reached full scale.

Function
REQ-014 SHALL implement states IDLE, RUN_UP, RUN_DOWN, DONE, all registered.
REQ-015 In IDLE, enb_cnt=1 at an edge: go to RUN_UP, count<=1.
REQ-016 In RUN_UP, each edge with enb_cnt=1: count<=count+1; enb_cnt=0: count holds.
REQ-017 In RUN_UP, enb_cnt=1 with count==FULL_COUNT-1: count<=0, state<=RUN_DOWN, enb_machine<=1 for exactly the next cycle.
REQ-018 enb_machine SHALL be 0 in every other cycle, including when enb_cnt is held high afterwards.
REQ-019 In RUN_DOWN, enb_cnt=1: count increments; at FULL_COUNT-1 it saturates and overrange<=1.
REQ-020 In RUN_DOWN, ld=1: result<=current registered count (pre-increment), result_valid<=1, state<=DONE; ld takes priority over enb_cnt in the same cycle.
REQ-021 ld in IDLE, RUN_UP or DONE SHALL be ignored; result and result_valid stay unchanged.
REQ-022 In DONE, count SHALL hold; enb_cnt=1 restarts as in REQ-015 and clears overrange.
REQ-023 clr=1: state<=IDLE, count<=0, enb_machine<=0, overrange<=0; result, result_valid unchanged; clr has priority over enb_cnt and ld.
REQ-024 result_ack=1 SHALL clear result_valid next edge; if a capture (REQ-020) occurs in the same cycle, result_valid SHALL stay 1 with the new result.
REQ-025 A capture while result_valid=1 SHALL overwrite result (no stall, no error flag).
REQ-026 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-027 rst=1 SHALL force state=IDLE, count=0, result=0, result_valid=0, enb_machine=0, overrange=0 at the next edge, in any state, overriding all other inputs.
REQ-028 rst mid-conversion SHALL discard the conversion; no enb_machine pulse or result capture follows until a new REQ-015 start.

Structure
REQ-029 State encoding and the FULL_COUNT/CNT_W defaults SHALL live in shared package dsc_pkg.
REQ-030 Counting SHALL be a sub-module dsc_mod_counter (enable, clear, load-one, saturate, terminal-count flag); dual_slope_counter holds the FSM and result register.

Verification (FULL_COUNT=16, CNT_W=5)
REQ-031 rst, then enb_cnt=1 held 16 cycles -> count 1..15 then 0, enb_machine high exactly one cycle, state RUN_DOWN.
REQ-032 After run-up, 9 more enb_cnt cycles then ld=1, enb_cnt=0 same cycle -> result=9, result_valid=1, count holds 9.
REQ-033 Run-down with enb_cnt held 20 cycles -> count saturates at 15, overrange=1; ld -> result=15.
REQ-034 result_valid=1, then new capture (result=5) with result_ack=1 same cycle -> result_valid stays 1, result=5; ack next cycle -> result_valid=0.
REQ-035 clr at run-up count 7 -> count=0, IDLE, no enb_machine pulse; prior result/result_valid preserved.
REQ-036 rst at run-down count 4 with ld=1 same cycle -> result=0, result_valid=0, count=0, no capture.
